// File: rtl/fpu_issue_queue.sv
// fpu_issue_queue
//   Issue-side buffer in front of the floating-point model stage. Offers from
//   the core arrive on a CORE-V-XIF-style issue handshake. Each offer is
//   decoded to decide whether it is an RV32F instruction owned by this unit.
//   Owned instructions are stored together with their id and integer operand
//   in an in-order FIFO. The FIFO drains into the FPU stage at most one entry
//   per cycle.
//
// Ports
//   ck, rst              clock; synchronous active-low reset
//   x_issue_valid/ready  issue handshake (offer consumed when both are high)
//   x_issue_instr/id/rs0 offered instruction word, id and integer operand
//   x_issue_accept       decode result: the offered word is ours
//   flush                drop every queued entry at the next edge
//   fpu_ready            downstream stage can take the head entry
//   fpu_enable           head entry is delivered this cycle
//   fpu_instruction/id/data_fromXreg  head entry (zero when empty)
//   count                number of occupied entries
module fpu_issue_queue #(
    parameter int DEPTH      = 4,
    parameter int X_ID_WIDTH = 4,
    parameter int XLEN       = 32
) (
    input  logic                     ck,
    input  logic                     rst,
    input  logic                     x_issue_valid,
    output logic                     x_issue_ready,
    input  logic [31:0]              x_issue_instr,
    input  logic [X_ID_WIDTH-1:0]    x_issue_id,
    input  logic [XLEN-1:0]          x_issue_rs0,
    output logic                     x_issue_accept,
    input  logic                     flush,
    input  logic                     fpu_ready,
    output logic                     fpu_enable,
    output logic [31:0]              fpu_instruction,
    output logic [X_ID_WIDTH-1:0]    fpu_id,
    output logic [XLEN-1:0]          fpu_data_fromXreg,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef struct packed {
        logic [31:0]           instr;
        logic [X_ID_WIDTH-1:0] id;
        logic [XLEN-1:0]       rs0;
    } entry_t;

    entry_t             mem_q [DEPTH];
    entry_t             mem_d [DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]   count_q, count_d;

    logic               push;
    logic               pop;
    logic               not_empty;
    entry_t             head;

    // Decode: RV32F single-precision loads/stores, OP-FP and the FMA family.
    always_comb begin
        x_issue_accept = 1'b0;
        case (x_issue_instr[6:0])
            7'b0000111, 7'b0100111:
                x_issue_accept = (x_issue_instr[14:12] == 3'b010);
            7'b1010011, 7'b1000011, 7'b1000111, 7'b1001011, 7'b1001111:
                x_issue_accept = (x_issue_instr[26:25] == 2'b00);
            default:
                x_issue_accept = 1'b0;
        endcase
    end

    assign not_empty = (count_q != '0);

    // Ready looks only at registered occupancy, so a full queue stays
    // not-ready even in a cycle where it pops (no path from fpu_ready).
    assign x_issue_ready = rst && !flush && (count_q < CNT_W'(DEPTH));
    assign fpu_enable    = rst && not_empty && fpu_ready && !flush;

    assign push = x_issue_valid && x_issue_ready && x_issue_accept;
    assign pop  = fpu_enable;

    // Head outputs are zeroed when there is nothing valid to show.
    always_comb begin
        head = '0;
        if (rst && not_empty) head = mem_q[rd_ptr_q];
    end

    assign fpu_instruction   = head.instr;
    assign fpu_id            = head.id;
    assign fpu_data_fromXreg = head.rs0;
    assign count             = count_q;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                mem_d[wr_ptr_q] = '{instr: x_issue_instr, id: x_issue_id, rs0: x_issue_rs0};
                wr_ptr_d        = wr_ptr_q + PTR_W'(1);
            end
            if (pop) rd_ptr_d = rd_ptr_q + PTR_W'(1);
            if (push && !pop)      count_d = count_q + CNT_W'(1);
            else if (pop && !push) count_d = count_q - CNT_W'(1);
        end
    end

    always_ff @(posedge ck) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Entry storage needs no reset; occupancy alone decides what is valid.
    always_ff @(posedge ck) begin
        mem_q <= mem_d;
    end

endmodule

// File: tb/tb_fpu_issue_queue.sv
module tb_fpu_issue_queue;

    logic        ck = 1'b0;
    logic        rst;
    logic        x_issue_valid;
    logic        x_issue_ready;
    logic [31:0] x_issue_instr;
    logic [3:0]  x_issue_id;
    logic [31:0] x_issue_rs0;
    logic        x_issue_accept;
    logic        flush;
    logic        fpu_ready;
    logic        fpu_enable;
    logic [31:0] fpu_instruction;
    logic [3:0]  fpu_id;
    logic [31:0] fpu_data_fromXreg;
    logic [2:0]  count;

    int pass_cnt = 0;
    int chk_cnt  = 0;

    logic [31:0] fp_tab [6];

    fpu_issue_queue #(.DEPTH(4), .X_ID_WIDTH(4), .XLEN(32)) dut (
        .ck                (ck),
        .rst               (rst),
        .x_issue_valid     (x_issue_valid),
        .x_issue_ready     (x_issue_ready),
        .x_issue_instr     (x_issue_instr),
        .x_issue_id        (x_issue_id),
        .x_issue_rs0       (x_issue_rs0),
        .x_issue_accept    (x_issue_accept),
        .flush             (flush),
        .fpu_ready         (fpu_ready),
        .fpu_enable        (fpu_enable),
        .fpu_instruction   (fpu_instruction),
        .fpu_id            (fpu_id),
        .fpu_data_fromXreg (fpu_data_fromXreg),
        .count             (count)
    );

    always #5 ck = ~ck;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        chk_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Inputs change 1 time unit after the rising edge; checks follow 1 unit later.
    task automatic tick();
        @(posedge ck);
        #1;
    endtask

    localparam logic [31:0] FLW = 32'h0005A507;

    initial begin
        fp_tab[0] = 32'h00000043;  // fmadd.s
        fp_tab[1] = 32'h00000047;  // fmsub.s
        fp_tab[2] = 32'h0000004B;  // fnmsub.s
        fp_tab[3] = 32'h0000004F;  // fnmadd.s
        fp_tab[4] = 32'h00B50553;  // fadd.s
        fp_tab[5] = 32'h0000A027;  // fsw

        rst = 1'b0; x_issue_valid = 1'b0; x_issue_instr = '0; x_issue_id = '0;
        x_issue_rs0 = '0; flush = 1'b0; fpu_ready = 1'b1;
        tick(); tick();
        check("rst_count", count, 0);
        check("rst_ready", x_issue_ready, 0);
        check("rst_enable", fpu_enable, 0);
        check("rst_head", fpu_instruction, 0);

        rst = 1'b1;
        tick();
        check("idle_ready", x_issue_ready, 1);
        check("empty_no_enable", fpu_enable, 0);

        // 1: single fadd.s
        x_issue_valid = 1'b1; x_issue_instr = 32'h00B50553; x_issue_id = 4'd3; x_issue_rs0 = 32'h1234;
        #1;
        check("t1_accept", x_issue_accept, 1);
        check("t1_enable_pre", fpu_enable, 0);
        tick();
        x_issue_valid = 1'b0;
        #1;
        check("t1_count1", count, 1);
        check("t1_enable", fpu_enable, 1);
        check("t1_instr", fpu_instruction, 32'h00B50553);
        check("t1_id", fpu_id, 3);
        check("t1_data", fpu_data_fromXreg, 32'h1234);
        tick();
        check("t1_count0", count, 0);
        check("t1_head_zero", fpu_id, 0);

        // 2: rejected encodings
        x_issue_valid = 1'b1; x_issue_instr = 32'h00B50533;
        #1;
        check("t2_add_reject", x_issue_accept, 0);
        tick();
        x_issue_instr = 32'h02B50553;
        #1;
        check("t2_faddd_reject", x_issue_accept, 0);
        check("t2_enable", fpu_enable, 0);
        tick();
        x_issue_instr = 32'h00059507;
        #1;
        check("t2_flh_reject", x_issue_accept, 0);
        tick();
        x_issue_valid = 1'b0;
        #1;
        check("t2_count", count, 0);
        check("t2_enable_end", fpu_enable, 0);

        // 3: fill, backpressure, drain
        fpu_ready = 1'b0;
        x_issue_valid = 1'b1; x_issue_instr = FLW;
        for (int i = 0; i < 4; i++) begin
            x_issue_id = 4'(i); x_issue_rs0 = 32'h100 + 32'(i);
            #1;
            check("t3_fill_ready", x_issue_ready, 1);
            check("t3_flw_accept", x_issue_accept, 1);
            tick();
        end
        x_issue_id = 4'd4; x_issue_rs0 = 32'h104;
        #1;
        check("t3_full_count", count, 4);
        check("t3_full_ready", x_issue_ready, 0);
        check("t3_stall_enable", fpu_enable, 0);
        tick();
        check("t3_hold_count", count, 4);
        check("t3_stall_head", fpu_id, 0);
        fpu_ready = 1'b1;
        #1;
        check("t3_no_bypass", x_issue_ready, 0);
        check("t3_pop0_en", fpu_enable, 1);
        check("t3_pop0_id", fpu_id, 0);
        tick();
        check("t3_ready_back", x_issue_ready, 1);
        check("t3_head1", fpu_id, 1);
        check("t3_data1", fpu_data_fromXreg, 32'h101);
        tick();
        x_issue_id = 4'd5; x_issue_rs0 = 32'h105;
        #1;
        check("t3_head2", fpu_id, 2);
        tick();
        x_issue_valid = 1'b0;
        for (int k = 3; k < 6; k++) begin
            #1;
            check("t3_drain_en", fpu_enable, 1);
            check("t3_drain_id", fpu_id, 64'(k));
            check("t3_drain_data", fpu_data_fromXreg, 64'(32'h100 + k));
            tick();
        end
        check("t3_empty", count, 0);

        // 4: streaming push+pop, pointers wrap
        x_issue_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            x_issue_id = 4'(i); x_issue_instr = fp_tab[i % 6]; x_issue_rs0 = 32'h200 + 32'(i);
            #1;
            check("t4_accept", x_issue_accept, 1);
            if (i > 0) begin
                check("t4_count", count, 1);
                check("t4_id", fpu_id, 64'(i - 1));
                check("t4_instr", fpu_instruction, fp_tab[(i - 1) % 6]);
            end
            tick();
        end
        x_issue_valid = 1'b0;
        #1;
        check("t4_last_id", fpu_id, 9);
        check("t4_last_count", count, 1);
        tick();
        check("t4_empty", count, 0);

        // 5a: flush with three entries queued
        fpu_ready = 1'b0; x_issue_valid = 1'b1; x_issue_instr = FLW;
        for (int i = 0; i < 3; i++) begin
            x_issue_id = 4'(10 + i);
            tick();
        end
        check("t5_count3", count, 3);
        flush = 1'b1; fpu_ready = 1'b1; x_issue_id = 4'd13;
        #1;
        check("t5_flush_enable", fpu_enable, 0);
        check("t5_flush_ready", x_issue_ready, 0);
        tick();
        flush = 1'b0; x_issue_valid = 1'b0;
        #1;
        check("t5_flush_count", count, 0);
        check("t5_flush_enable_after", fpu_enable, 0);
        x_issue_valid = 1'b1; x_issue_id = 4'd14;
        tick();
        x_issue_valid = 1'b0;
        #1;
        check("t5_post_flush_id", fpu_id, 14);
        check("t5_post_flush_count", count, 1);
        tick();

        // 5b: reset with three entries queued
        fpu_ready = 1'b0; x_issue_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            x_issue_id = 4'(10 + i);
            tick();
        end
        check("t5r_count3", count, 3);
        rst = 1'b0; fpu_ready = 1'b1; x_issue_id = 4'd13;
        #1;
        check("t5r_enable", fpu_enable, 0);
        check("t5r_ready", x_issue_ready, 0);
        check("t5r_head", fpu_id, 0);
        tick();
        rst = 1'b1; x_issue_valid = 1'b0;
        #1;
        check("t5r_count", count, 0);
        x_issue_valid = 1'b1; x_issue_id = 4'd15;
        tick();
        x_issue_valid = 1'b0;
        #1;
        check("t5r_post_id", fpu_id, 15);
        check("t5r_post_en", fpu_enable, 1);
        tick();
        check("t5r_final_count", count, 0);

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
